mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have parameter: EN_MEM_WAIT, 1, 1 = memory states wait for mem_ready; 0 = mem_ready treated as constant 1.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: Instr  input  32  instruction register contents (cond [31:28], Op [27:26], Funct [25:20], Rd [15:12]).
REQ-005 SHALL have port: ALUFlags  input  4  NZCV from ALU, current cycle.
REQ-006 SHALL have port: mem_ready  input  1  memory completes access this cycle.
REQ-007 SHALL have ports: PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath enables/selects.
REQ-008 SHALL have ports: ResultSrc, ALUSrcA, ALUSrcB  output  2 each  mux selects; encodings from package.
REQ-009 SHALL have port: ALUControl  output  4  ARM data-processing cmd code.
REQ-010 SHALL have ports: Flags  output  4  stored NZCV; state  output  4  current state (debug).

Function
REQ-011 SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
REQ-012 FETCH: AdrSrc=0, ALUSrcA=PC, ALUSrcB=4, ResultSrc=ALU; IRWrite and PCWrite only in the cycle mem_ready=1; hold FETCH while mem_ready=0; then DECODE.
REQ-013 DECODE: ALUSrcA=PC, ALUSrcB=4 (PC+8); evaluate cond against stored Flags; fail -> FETCH with no write enables.
REQ-014 DECODE pass: Op=01 -> MEMADR; Op=10 -> BRANCH; Op=00 with Funct[5]=1 -> EXECI, else EXECR; Op=11 -> FETCH (undefined, no effect).
REQ-015 MEMADR: Rn+imm; Funct[0]=1 -> MEMREAD, else MEMWRITE.
REQ-016 MEMREAD: AdrSrc=1; hold until mem_ready; then MEMWB. MEMWB: ResultSrc=Data, RegWrite=1; -> FETCH.
REQ-017 MEMWRITE: AdrSrc=1, MemWrite=1 every cycle until mem_ready; -> FETCH.
REQ-018 EXECR/EXECI: ALUControl=Instr[24:21]; ALUSrcB=reg or imm; if Funct[0]=1 latch ALUFlags into Flags at cycle end.
REQ-019 EXECx -> FETCH when cmd in TST/TEQ/CMP/CMN (10xx), else ALUWB.
REQ-020 ALUWB: RegWrite=1, ResultSrc=ALUOut; if Rd=15 also PCWrite=1; -> FETCH.
REQ-021 BRANCH: ALUSrcA=PC, ALUSrcB=imm, ResultSrc=ALU, PCWrite=1; -> FETCH.
REQ-022 ALUControl SHALL be ADD (0100) in all states except EXECR/EXECI.
REQ-023 Flags SHALL change only per REQ-018; all write enables default 0 outside stated states.
REQ-024 Latency with mem_ready=1: DP 4 cycles, compare 3, LDR 5, STR 4, B 3, cond-fail 2; each wait cycle adds 1.

Reset
REQ-025 reset low SHALL force state=FETCH and Flags=0000 immediately, including mid-access; all enables 0 while held.
REQ-026 First FETCH SHALL begin on the first rising edge after reset deasserts; no partial write completes.

Structure
REQ-027 Package mc_pkg SHALL hold state enum, ResultSrc/ALUSrcA/ALUSrcB encodings, ALU cmd constants (ADD, compare prefix).
REQ-028 One combinational sub-module cond_eval SHALL map cond[3:0]+Flags to pass (all 15 ARM conds; 1111 = fail).

Verification
REQ-029 ADDS R1,R2,R3 (E0921003), ALUFlags=0110 -> state FETCH,DECODE,EXECR,ALUWB; RegWrite only in ALUWB; Flags=0110.
REQ-030 BEQ with Flags Z=0 -> FETCH,DECODE,FETCH; PCWrite once (fetch); no RegWrite/MemWrite.
REQ-031 LDR, mem_ready low 3 cycles in MEMREAD -> 8 total cycles, RegWrite in MEMWB only.
REQ-032 STR, mem_ready low 2 cycles -> MemWrite high 3 consecutive cycles, then FETCH.
REQ-033 reset asserted during MEMWRITE -> MemWrite drops same cycle, state=FETCH, Flags=0000.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control sequencer: state encoding,
// datapath mux encodings, ALU command constants and the per-state control
// word decode used by mc_sequencer.
package mc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 4;

  // Sequencer states; the encoding is also visible on the debug state port
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // ResultSrc encodings
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  // ALUSrcA encodings
  localparam logic [SEL_W-1:0] SRCA_REG   = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b01;

  // ALUSrcB encodings
  localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  // ALU commands: ADD for address/PC arithmetic, 10xx are flag-only compares
  localparam logic [CMD_W-1:0] CMD_ADD     = 4'b0100;
  localparam logic [1:0]       CMD_CMP_PFX = 2'b10;

  // Instruction Op field
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Control word held in registers for the current state
  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic             adr_src;
    logic             pc_write;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [CMD_W-1:0] alu_control;
  } ctl_t;

  // Control word for a state; the fetch handshake enables are added separately
  function automatic ctl_t decode_ctl(input state_t s, input logic [CMD_W-1:0] cmd,
                                      input logic rd_pc);
    ctl_t c;
    c             = '0;
    c.result_src  = RES_ALUOUT;
    c.alu_src_a   = SRCA_REG;
    c.alu_src_b   = SRCB_REG;
    c.alu_control = CMD_ADD;
    case (s)
      S_FETCH: begin
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
      end
      S_MEMADR: begin
        c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECR: begin
        c.alu_control = cmd;
      end
      S_EXECI: begin
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = cmd;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.pc_write  = rd_pc;
      end
      S_BRANCH: begin
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALU;
        c.pc_write   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator.
// Ports: cond - instruction condition field; flags - stored NZCV;
//        pass_c - 1 when the instruction should execute (1111 never passes).
module cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass_c
);

  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  // Full 16-entry decode of the condition field
  always_comb begin
    pass_c = 1'b0;
    case (cond)
      4'b0000: pass_c = z;
      4'b0001: pass_c = ~z;
      4'b0010: pass_c = c;
      4'b0011: pass_c = ~c;
      4'b0100: pass_c = n;
      4'b0101: pass_c = ~n;
      4'b0110: pass_c = v;
      4'b0111: pass_c = ~v;
      4'b1000: pass_c = c & ~z;
      4'b1001: pass_c = ~c | z;
      4'b1010: pass_c = (n == v);
      4'b1011: pass_c = (n != v);
      4'b1100: pass_c = ~z & (n == v);
      4'b1101: pass_c = z | (n != v);
      4'b1110: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle ARM-subset control sequencer.
// Ports: clk, reset (async active-low); Instr - IR contents; ALUFlags - NZCV
// from the ALU this cycle; mem_ready - memory completes access this cycle.
// Outputs: datapath enables (PCWrite, IRWrite, RegWrite, MemWrite), selects
// (AdrSrc, ResultSrc, ALUSrcA, ALUSrcB), ALUControl, stored Flags, debug state.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter bit EN_MEM_WAIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [FLAGS_W-1:0] ALUFlags,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic [SEL_W-1:0]   ResultSrc,
  output logic [SEL_W-1:0]   ALUSrcA,
  output logic [SEL_W-1:0]   ALUSrcB,
  output logic [CMD_W-1:0]   ALUControl,
  output logic [FLAGS_W-1:0] Flags,
  output logic [STATE_W-1:0] state
);

  state_t             state_q;
  state_t             state_nxt;
  logic               active_q;
  ctl_t               ctl_q;
  ctl_t               ctl_nxt;
  logic [FLAGS_W-1:0] flags_q;
  logic               mem_rdy;
  logic               cond_pass;
  logic               fetch_go;
  logic               flag_upd;

  logic [3:0]         cond_f;
  logic [1:0]         op_f;
  logic [5:0]         funct_f;
  logic [3:0]         rd_f;
  logic [CMD_W-1:0]   cmd_f;
  logic               unused_instr;

  assign cond_f       = Instr[31:28];
  assign op_f         = Instr[27:26];
  assign funct_f      = Instr[25:20];
  assign rd_f         = Instr[15:12];
  assign cmd_f        = Instr[24:21];
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  assign mem_rdy = EN_MEM_WAIT ? mem_ready : 1'b1;

  cond_eval u_cond_eval (
    .cond   (cond_f),
    .flags  (flags_q),
    .pass_c (cond_pass)
  );

  // Next-state logic; held in FETCH until the first clock after reset release
  always_comb begin
    state_nxt = state_q;
    if (!active_q) begin
      state_nxt = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:    if (mem_rdy) state_nxt = S_DECODE;
        S_DECODE: begin
          if (!cond_pass) begin
            state_nxt = S_FETCH;
          end else begin
            case (op_f)
              OP_MEM:  state_nxt = S_MEMADR;
              OP_BR:   state_nxt = S_BRANCH;
              OP_DP:   state_nxt = funct_f[5] ? S_EXECI : S_EXECR;
              default: state_nxt = S_FETCH;
            endcase
          end
        end
        S_MEMADR:   state_nxt = funct_f[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_rdy) state_nxt = S_MEMWB;
        S_MEMWB:    state_nxt = S_FETCH;
        S_MEMWRITE: if (mem_rdy) state_nxt = S_FETCH;
        S_EXECR,
        S_EXECI:    state_nxt = (cmd_f[3:2] == CMD_CMP_PFX) ? S_FETCH : S_ALUWB;
        S_ALUWB:    state_nxt = S_FETCH;
        S_BRANCH:   state_nxt = S_FETCH;
        default:    state_nxt = S_FETCH;
      endcase
    end
  end

  // Control word for the state being entered, so the outputs come from flops
  assign ctl_nxt  = decode_ctl(state_nxt, cmd_f, (rd_f == 4'hF));

  // S-bit data-processing instructions capture NZCV at the end of execute
  assign flag_upd = ((state_q == S_EXECR) || (state_q == S_EXECI)) && funct_f[0];

  // State, control word and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      active_q <= 1'b0;
      ctl_q    <= decode_ctl(S_FETCH, CMD_ADD, 1'b0);
      flags_q  <= '0;
    end else begin
      state_q  <= state_nxt;
      active_q <= 1'b1;
      ctl_q    <= ctl_nxt;
      if (flag_upd) flags_q <= ALUFlags;
    end
  end

  // The instruction fetch commits only in the cycle memory answers
  assign fetch_go   = active_q && (state_q == S_FETCH) && mem_rdy;

  assign IRWrite    = fetch_go;
  assign PCWrite    = ctl_q.pc_write | fetch_go;
  assign RegWrite   = ctl_q.reg_write;
  assign MemWrite   = ctl_q.mem_write;
  assign AdrSrc     = ctl_q.adr_src;
  assign ResultSrc  = ctl_q.result_src;
  assign ALUSrcA    = ctl_q.alu_src_a;
  assign ALUSrcB    = ctl_q.alu_src_b;
  assign ALUControl = ctl_q.alu_control;
  assign Flags      = flags_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed vector table, hand-written
// corner sequences and random instructions against a transaction-level model.
module tb_mc_sequencer;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0]  ALUControl, Flags, state;

  int checks = 0;
  int errors = 0;

  int tr_state[$];
  int tr_regw[$];
  int tr_alu[$];
  int tr_sel[$];

  typedef struct {
    int         cyc;
    int         regw;
    int         memw;
    int         pcw;
    int         irw;
    logic [3:0] flags;
    bit         timeout;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  af;
    int          fw;
    int          mw;
    int          cyc;
    int          regw;
    int          memw;
    int          pcw;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[14];

  mc_sequencer #(.EN_MEM_WAIT(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Condition pass: even codes test a base predicate, odd codes invert it
  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  // Instruction-level model: cycle count, enable-cycle counts, resulting flags
  function automatic obs_t ref_txn(input logic [31:0] ins, input logic [3:0] fl,
                                   input logic [3:0] af, input int fw, input int mw);
    obs_t e;
    e = '{default: 0};
    e.cyc = fw + 2; e.irw = 1; e.pcw = 1; e.flags = fl;
    if (ref_cond(ins[31:28], fl)) begin
      case (ins[27:26])
        2'b01: begin
          if (ins[20]) begin e.cyc += 3 + mw; e.regw = 1; end
          else begin e.cyc += 2 + mw; e.memw = 1 + mw; end
        end
        2'b10: begin e.cyc += 1; e.pcw += 1; end
        2'b00: begin
          e.cyc += 1;
          if (ins[20]) e.flags = af;
          if (ins[24:23] != 2'b10) begin
            e.cyc += 1; e.regw = 1;
            if (ins[15:12] == 4'hF) e.pcw += 1;
          end
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // mem_ready schedule: fw stall cycles on fetch, mw on the data access
  function automatic logic ready_at(input int c, input int fw, input int mw);
    if (c < fw) return 1'b0;
    if (c >= fw + 3 && c < fw + 3 + mw) return 1'b0;
    return 1'b1;
  endfunction

  // Runs one instruction from FETCH back to FETCH; starts just after a rising edge
  task automatic run_txn(input logic [31:0] ins, input logic [3:0] af,
                         input int fw, input int mw, output obs_t o);
    bit seen_fetch, done;
    o = '{default: 0};
    tr_state.delete(); tr_regw.delete(); tr_alu.delete(); tr_sel.delete();
    Instr = ins; ALUFlags = af;
    seen_fetch = 1'b0; done = 1'b0;
    while (!done && o.cyc < 60) begin
      mem_ready = ready_at(o.cyc, fw, mw);
      @(negedge clk);
      tr_state.push_back(int'(state));
      tr_regw.push_back(int'(RegWrite));
      tr_alu.push_back(int'(ALUControl));
      tr_sel.push_back(int'({ResultSrc, ALUSrcA, ALUSrcB}));
      o.regw += int'(RegWrite);
      o.memw += int'(MemWrite);
      o.pcw  += int'(PCWrite);
      o.irw  += int'(IRWrite);
      if (IRWrite) seen_fetch = 1'b1;
      @(posedge clk); #1;
      o.cyc++;
      if (seen_fetch && state == 4'd0) done = 1'b1;
    end
    o.flags = Flags;
    o.timeout = !done;
    mem_ready = 1'b1;
  endtask

  task automatic cmp_obs(input string tag, input obs_t o, input obs_t e);
    check({tag, " timeout"}, int'(o.timeout), 0);
    check({tag, " cycles"},  o.cyc,  e.cyc);
    check({tag, " regw"},    o.regw, e.regw);
    check({tag, " memw"},    o.memw, e.memw);
    check({tag, " pcw"},     o.pcw,  e.pcw);
    check({tag, " irw"},     o.irw,  e.irw);
    check({tag, " flags"},   int'(o.flags), int'(e.flags));
  endtask

  task automatic do_reset();
    reset = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o, e;
    logic [3:0] m_flags;
    int exp_st[4];
    int exp_rw[4];

    // instr, ALUFlags, fetch waits, mem waits, cycles, regw, memw, pcw, flags
    vecs[0]  = '{32'h0A000010, 4'h0, 0, 0, 2, 0, 0, 1, 4'h0}; // BEQ, Z=0 fails
    vecs[1]  = '{32'hE0921003, 4'h6, 0, 0, 4, 1, 0, 1, 4'h6}; // ADDS
    vecs[2]  = '{32'h0A000010, 4'h0, 0, 0, 3, 0, 0, 2, 4'h6}; // BEQ, Z=1 taken
    vecs[3]  = '{32'hE5912004, 4'h0, 0, 3, 8, 1, 0, 1, 4'h6}; // LDR, 3 waits
    vecs[4]  = '{32'hE5812004, 4'h0, 0, 2, 6, 0, 3, 1, 4'h6}; // STR, 2 waits
    vecs[5]  = '{32'hE1520003, 4'h8, 0, 0, 3, 0, 0, 1, 4'h8}; // CMP
    vecs[6]  = '{32'hE082F003, 4'h1, 0, 0, 4, 1, 0, 2, 4'h8}; // ADD PC
    vecs[7]  = '{32'hE3911001, 4'h3, 0, 0, 4, 1, 0, 1, 4'h3}; // ORRS imm
    vecs[8]  = '{32'hF0800000, 4'hF, 0, 0, 2, 0, 0, 1, 4'h3}; // cond 1111
    vecs[9]  = '{32'hEC000000, 4'h0, 0, 0, 2, 0, 0, 1, 4'h3}; // Op=11
    vecs[10] = '{32'hE0821003, 4'hF, 2, 0, 6, 1, 0, 1, 4'h3}; // ADD, fetch waits
    vecs[11] = '{32'h1A000000, 4'h0, 0, 0, 3, 0, 0, 2, 4'h3}; // BNE taken
    vecs[12] = '{32'hAA000000, 4'h0, 0, 0, 2, 0, 0, 1, 4'h3}; // BGE fails
    vecs[13] = '{32'h8A000000, 4'h0, 0, 0, 3, 0, 0, 2, 4'h3}; // BHI taken

    reset = 1'b0; Instr = '0; ALUFlags = '0; mem_ready = 1'b1;
    #12;
    check("reset state",   int'(state), 0);
    check("reset flags",   int'(Flags), 0);
    check("reset irwrite", int'(IRWrite), 0);
    check("reset pcwrite", int'(PCWrite), 0);
    check("reset memwrite", int'(MemWrite), 0);
    @(negedge clk) reset = 1'b1;
    #1 check("pre-edge irwrite", int'(IRWrite), 0);
    @(posedge clk); #1;
    check("first fetch irwrite", int'(IRWrite), 1);

    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].instr, vecs[i].af, vecs[i].fw, vecs[i].mw, o);
      e = '{default: 0};
      e.cyc = vecs[i].cyc; e.regw = vecs[i].regw; e.memw = vecs[i].memw;
      e.pcw = vecs[i].pcw; e.irw = 1; e.flags = vecs[i].flags;
      cmp_obs($sformatf("vec%0d", i), o, e);
    end

    // ADDS state trace with RegWrite only in write-back
    exp_st = '{0, 1, 6, 8};
    exp_rw = '{0, 0, 0, 1};
    run_txn(32'hE0921003, 4'h6, 0, 0, o);
    check("adds trace len", tr_state.size(), 4);
    if (tr_state.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("adds state[%0d]", i), tr_state[i], exp_st[i]);
        check($sformatf("adds regw[%0d]", i),  tr_regw[i],  exp_rw[i]);
      end
    end
    check("adds flags", int'(Flags), 6);

    // ORRS immediate: fetch selects, then execute command and immediate operand
    run_txn(32'hE3911001, 4'h3, 0, 0, o);
    check("orrs trace len", tr_alu.size(), 4);
    if (tr_alu.size() >= 3) begin
      check("fetch alucontrol", tr_alu[0], 4);
      check("fetch selects", tr_sel[0], int'({RES_ALU, SRCA_PC, SRCB_FOUR}));
      check("execi alucontrol", tr_alu[2], 12);
      check("execi srcb", tr_sel[2] & 3, int'(SRCB_IMM));
    end

    // Reset in the middle of a stalled store
    Instr = 32'hE5812004; mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midwrite state", int'(state), 5);
    check("midwrite memwrite", int'(MemWrite), 1);
    #2 reset = 1'b0;
    #1;
    check("reset memwrite drop", int'(MemWrite), 0);
    check("reset adrsrc drop", int'(AdrSrc), 0);
    check("reset state fetch", int'(state), 0);
    check("reset flags clear", int'(Flags), 0);
    @(negedge clk) reset = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;

    // Random instructions against the model
    m_flags = 4'h0;
    for (int t = 0; t < 80; t++) begin
      logic [31:0] ins;
      logic [3:0]  af;
      int          fw, mw;
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
      af = 4'($urandom);
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      e = ref_txn(ins, m_flags, af, fw, mw);
      run_txn(ins, af, fw, mw, o);
      cmp_obs($sformatf("rand%0d %h", t, ins), o, e);
      m_flags = e.flags;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
